// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchroniser, oversampled 2-of-3 majority voting, one-byte holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the last data bit and the stop bit.
module uart_receiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic [2:0] state_o
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, WAIT_IDLE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4, WAIT_IDLE = 3'd5
  } state_t;
`endif

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [TW-1:0]   tick_q, tick_d;
  logic [SW-1:0]   samp_q, samp_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            v0_q, v0_d, v1_q, v1_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            rx_s, tick, vote, byte_done;

  assign rx_s = sync2_q;
  assign tick = (tick_q == T_LAST);
  assign vote = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif

  always_comb begin
    state_d   = state_q;
    tick_d    = tick ? '0 : tick_q + TW'(1);
    samp_d    = samp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    v0_d      = v0_q;
    v1_d      = v1_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    byte_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif

    // Sample counter and the two early vote samples advance only while framing a bit.
    if (tick && state_q != IDLE && state_q != WAIT_IDLE) begin
      samp_d = (samp_q == S_LAST) ? '0 : samp_q + SW'(1);
      if (samp_q == S_V0) v0_d = rx_s;
      if (samp_q == S_V1) v1_d = rx_s;
    end

    case (state_q)
      IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = START;
          samp_d  = '0;
          tick_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (samp_q == S_V1 && rx_s) begin
            state_d = IDLE;
          end else if (samp_q == S_LAST) begin
            state_d = DATA;
            bit_d   = 3'd0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (samp_q == S_V2) shift_d = {vote, shift_q[7:1]};
          if (samp_q == S_LAST) begin
            bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_q == 3'd7) state_d = PARITY;
`else
            if (bit_q == 3'd7) state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (samp_q == S_V2) par_d = vote;
          if (samp_q == S_LAST) state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && samp_q == S_V2) begin
          state_d = IDLE;
          if (!vote) begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
`ifdef UART_RX_PARITY_EN
          else if (^{shift_q, par_q}) perr_d = 1'b1;
`endif
          else byte_done = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Holding register: a completed byte wins over an acceptance in the same cycle.
    if (byte_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      tick_q  <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= tick_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frames driven at 434 clk/bit, bytes and error
// pulses compared against an expected-byte queue and expected pulse counts.
module tb_uart_receiver;

  localparam int BIT_CLKS = 434;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, parity_err;
  logic [2:0] state_o;

  uart_receiver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_pin     (rx_pin),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .state_o    (state_o)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  initial begin
    #(20 * 120000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int acc_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
  int exp_acc = 0, exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  bit rand_ready = 1'b0;
  bit hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: accepted bytes against the expected queue, stability while stalled, pulse counts.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (hold_prev) begin
        check_eq("hold_valid", {31'd0, rx_valid}, 32'd1);
        check_eq("hold_data", {24'd0, rx_data}, {24'd0, data_prev});
      end
      if (rx_valid && rx_ready) begin
        acc_cnt++;
        check_eq("byte_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) check_eq("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
      if (frame_err)  ferr_cnt++;
      if (overrun)    ovr_cnt++;
      if (parity_err) perr_cnt++;
      hold_prev = rx_valid && !rx_ready;
      data_prev = rx_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic set_ready(input logic v);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    rx_ready = v;
  endtask

  task automatic drive_bit(input logic v);
    rx_pin = v;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit((^b) ^ ~par_ok);
    drive_bit(stop_ok);
    rx_pin = 1'b1;
    if (!stop_ok) repeat (BIT_CLKS) @(posedge clk);
  endtask

  task automatic wait_acc(input string tag);
    for (int i = 0; i < 3000 && acc_cnt < exp_acc; i++) @(negedge clk);
    check_eq({tag, "_accepts"}, acc_cnt, exp_acc);
  endtask

  task automatic check_counts(input string tag);
    repeat (20) @(negedge clk);
    check_eq({tag, "_frame_err"}, ferr_cnt, exp_ferr);
    check_eq({tag, "_overrun"}, ovr_cnt, exp_ovr);
    check_eq({tag, "_parity_err"}, perr_cnt, exp_perr);
    check_eq({tag, "_accepts"}, acc_cnt, exp_acc);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check_eq({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check_eq({tag, "_errs"}, {29'd0, frame_err, overrun, parity_err}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    bit stop_ok, par_ok;

    repeat (5) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_idle_outputs("post_reset");
    set_ready(1'b1);

    // Single byte, consumer always ready
    exp_q.push_back(8'hA5); exp_acc++;
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_acc("a5");
    check_counts("a5");

    // Back-to-back frames
    exp_q.push_back(8'h55); exp_q.push_back(8'hAA); exp_acc += 2;
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hAA, 1'b1, 1'b1);
    wait_acc("b2b");
    check_counts("b2b");

    // Randomized bytes, stop/parity faults and consumer stalls
    rand_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      par_ok = PAR_EN ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!stop_ok) exp_ferr++;
      else if (!par_ok) exp_perr++;
      else begin
        exp_q.push_back(b);
        exp_acc++;
      end
      send_frame(b, stop_ok, par_ok);
      repeat ($urandom_range(0, 60)) @(posedge clk);
    end
    wait_acc("rand");
    set_ready(1'b1);
    check_counts("rand");

    // Overrun: holding register full, second byte dropped
    set_ready(1'b0);
    exp_q.push_back(8'h42); exp_acc++; exp_ovr++;
    send_frame(8'h42, 1'b1, 1'b1);
    send_frame(8'h13, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check_eq("ovr_data", {24'd0, rx_data}, 32'h42);
    check_eq("ovr_count", ovr_cnt, exp_ovr);
    set_ready(1'b1);
    repeat (2) @(negedge clk);
    check_eq("ovr_cleared", {31'd0, rx_valid}, 32'd0);
    check_counts("ovr");

    // Bad stop bit, then a clean frame
    exp_ferr++;
    send_frame(8'h3C, 1'b0, 1'b1);
    check_eq("ferr_valid", {31'd0, rx_valid}, 32'd0);
    check_counts("ferr");
    exp_q.push_back(8'h81); exp_acc++;
    send_frame(8'h81, 1'b1, 1'b1);
    wait_acc("after_ferr");
    check_counts("after_ferr");

    // Short low glitch on an idle line
    rx_pin = 1'b0;
    repeat (100) @(posedge clk);
    rx_pin = 1'b1;
    repeat (1000) @(negedge clk);
    check_eq("glitch_valid", {31'd0, rx_valid}, 32'd0);
    check_counts("glitch");

    // Reset in the middle of a frame
    drive_bit(1'b0);
    b = 8'hF0;
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("mid_reset");
    rx_pin = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    exp_q.push_back(8'h0F); exp_acc++;
    send_frame(8'h0F, 1'b1, 1'b1);
    wait_acc("after_reset");
    check_counts("after_reset");

`ifdef UART_RX_PARITY_EN
    exp_perr++;
    send_frame(8'h07, 1'b1, 1'b0);
    check_eq("perr_valid", {31'd0, rx_valid}, 32'd0);
    check_counts("perr");
    exp_q.push_back(8'h07); exp_acc++;
    send_frame(8'h07, 1'b1, 1'b1);
    wait_acc("par_ok");
    check_counts("par_ok");
`endif

    check_eq("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
